// File: rtl/display_scan_pkg.sv
// Shared definitions for the HH.MM.SS multiplexed seven-segment display.
package display_pkg;

  localparam int unsigned NUM_DIGITS = 6;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Digit positions; the value doubles as the anode bit number
  typedef enum logic [2:0] {
    IDX_S0 = 3'd0,
    IDX_S1 = 3'd1,
    IDX_M0 = 3'd2,
    IDX_M1 = 3'd3,
    IDX_H0 = 3'd4,
    IDX_H1 = 3'd5
  } digit_idx_e;

  function automatic digit_idx_e next_idx(input digit_idx_e cur);
    case (cur)
      IDX_S0:  return IDX_S1;
      IDX_S1:  return IDX_M0;
      IDX_M0:  return IDX_M1;
      IDX_M1:  return IDX_H0;
      IDX_H0:  return IDX_H1;
      default: return IDX_S0;
    endcase
  endfunction

endpackage

// File: rtl/display_scan_bcd_to_seg.sv
// BCD digit to active-low seven-segment pattern; non-decimal codes show a dash.
module bcd_to_seg
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Pure lookup, dash for 10..15
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_scan.sv
// Six-digit multiplexed HH.MM.SS display driver with per-frame snapshot
// and alarm blink. All display outputs are registered (one cycle latency).
module display_scan
  import display_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 4,
  parameter int unsigned BLINK_DIV = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] H_in1,
  input  logic [2:0] H_in0,
  input  logic [3:0] M_in1,
  input  logic [3:0] M_in0,
  input  logic [3:0] S_in1,
  input  logic [3:0] S_in0,
  input  logic       Alarm,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an,
  output logic [2:0] digit_sel
);

  localparam int unsigned SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int unsigned FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);

  typedef enum logic {BLINK_ON, BLINK_OFF} blink_e;

  logic [SW-1:0] scan_cnt;
  digit_idx_e    idx;
  logic          fresh;
  logic [3:0]    snap [NUM_DIGITS];
  logic [FW-1:0] frame_cnt, frame_cnt_nxt;
  blink_e        blink, blink_nxt;
  logic          slot_end, frame_end;
  logic [6:0]    dec_seg, seg_nxt;
  logic [5:0]    an_nxt;
  logic          dp_nxt;

  // Slot and frame boundary strobes
  always_comb begin
    slot_end  = (scan_cnt == SCAN_LAST);
    frame_end = slot_end && (idx == IDX_H1);
  end

  // Slot timer and digit index; fresh marks the first cycle out of reset
  always_ff @(posedge clock) begin
    if (reset) begin
      scan_cnt <= '0;
      idx      <= IDX_S0;
      fresh    <= 1'b1;
    end else begin
      fresh    <= 1'b0;
      scan_cnt <= slot_end ? '0 : scan_cnt + 1'b1;
      if (slot_end) idx <= next_idx(idx);
    end
  end

  // Capture all six digits together so one frame never mixes two times
  always_ff @(posedge clock) begin
    if (reset) begin
      snap <= '{default: '0};
    end else if (fresh || frame_end) begin
      snap[IDX_S0] <= S_in0;
      snap[IDX_S1] <= S_in1;
      snap[IDX_M0] <= M_in0;
      snap[IDX_M1] <= M_in1;
      snap[IDX_H0] <= {1'b0, H_in0};
      snap[IDX_H1] <= {2'b00, H_in1};
    end
  end

  // Blink phase state register
  always_ff @(posedge clock) begin
    if (reset) begin
      blink     <= BLINK_ON;
      frame_cnt <= '0;
    end else begin
      blink     <= blink_nxt;
      frame_cnt <= frame_cnt_nxt;
    end
  end

  // Blink next state: Alarm low wins over a coincident frame wrap
  always_comb begin
    blink_nxt     = blink;
    frame_cnt_nxt = frame_cnt;
    if (!Alarm) begin
      blink_nxt     = BLINK_ON;
      frame_cnt_nxt = '0;
    end else if (frame_end) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt_nxt = '0;
        blink_nxt     = (blink == BLINK_ON) ? BLINK_OFF : BLINK_ON;
      end else begin
        frame_cnt_nxt = frame_cnt + 1'b1;
      end
    end
  end

  bcd_to_seg u_dec (
    .bcd (snap[idx]),
    .seg (dec_seg)
  );

  // Next display outputs; Alarm gates the OFF phase directly so that
  // dropping Alarm restores the display on the very next cycle
  always_comb begin
    an_nxt  = '1;
    seg_nxt = SEG_BLANK;
    dp_nxt  = 1'b1;
    if (blink == BLINK_ON || !Alarm) begin
      seg_nxt = dec_seg;
      dp_nxt  = !(idx == IDX_M0 || idx == IDX_H0);
      if (scan_cnt != '0 && !(idx == IDX_H1 && snap[IDX_H1] == 4'd0))
        an_nxt[idx] = 1'b0;
    end
  end

  // Output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      an        <= '1;
      seg       <= SEG_BLANK;
      dp        <= 1'b1;
      digit_sel <= '0;
    end else begin
      an        <= an_nxt;
      seg       <= seg_nxt;
      dp        <= dp_nxt;
      digit_sel <= idx;
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan: frame-position model plus directed literal pins.
module tb_display_scan;

  localparam int SD    = 4;
  localparam int BD    = 8;
  localparam int FRAME = 6 * SD;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] H_in1 = '0;
  logic [2:0] H_in0 = '0;
  logic [3:0] M_in1 = '0, M_in0 = '0, S_in1 = '0, S_in0 = '0;
  logic       Alarm = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;
  logic [2:0] digit_sel;

  int checks   = 0;
  int failures = 0;

  display_scan #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clock     (clock),
    .reset     (reset),
    .H_in1     (H_in1),
    .H_in0     (H_in0),
    .M_in1     (M_in1),
    .M_in0     (M_in0),
    .S_in1     (S_in1),
    .S_in0     (S_in0),
    .Alarm     (Alarm),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .digit_sel (digit_sel)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0] seg_tab [16];
  initial begin
    seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
    seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
    seg_tab[8] = 7'h00; seg_tab[9] = 7'h10;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'h3F;
  end

  // mn: frame position the next non-reset edge will display
  int         mn = 0;
  int         wraps = 0;
  int         m_pos, m_sc, shown_pos = -1;
  logic [2:0] m_idx;
  logic       m_off;
  logic [3:0] msnap [6];
  logic       mvalid = 1'b0;
  logic [5:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp, e_segchk;
  logic [2:0] e_sel;

  always_comb begin
    m_pos = mn % FRAME;
    m_idx = 3'(m_pos / SD);
    m_sc  = mn % SD;
    m_off = Alarm && (((wraps / BD) % 2) == 1);
  end

  always @(posedge clock) begin
    mvalid <= 1'b1;
    if (reset) begin
      e_an <= 6'h3F; e_seg <= 7'h7F; e_dp <= 1'b1; e_sel <= 3'd0; e_segchk <= 1'b1;
      mn <= 0; wraps <= 0; shown_pos <= -1;
      msnap <= '{default: 4'd0};
    end else begin
      e_sel     <= m_idx;
      shown_pos <= m_pos;
      if (m_off) begin
        e_an <= 6'h3F; e_seg <= 7'h7F; e_dp <= 1'b1; e_segchk <= 1'b1;
      end else begin
        e_an     <= (m_sc == 0 || (m_idx == 3'd5 && msnap[5] == 4'd0)) ? 6'h3F : ~(6'd1 << m_idx);
        e_segchk <= !(m_sc == 0 || (m_idx == 3'd5 && msnap[5] == 4'd0));
        e_seg    <= seg_tab[msnap[m_idx]];
        e_dp     <= !(m_idx == 3'd2 || m_idx == 3'd4);
      end
      if (!Alarm) wraps <= 0;
      else if (m_pos == FRAME - 1) wraps <= wraps + 1;
      if (mn == 0 || m_pos == FRAME - 1) begin
        msnap[0] <= S_in0; msnap[1] <= S_in1; msnap[2] <= M_in0;
        msnap[3] <= M_in1; msnap[4] <= {1'b0, H_in0}; msnap[5] <= {2'b00, H_in1};
      end
      mn <= mn + 1;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clock) begin
    if (mvalid) begin
      check("digit_sel", 32'(digit_sel), 32'(e_sel));
      check("an", 32'(an), 32'(e_an));
      check("dp", 32'(dp), 32'(e_dp));
      if (e_segchk) check("seg", 32'(seg), 32'(e_seg));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_pos(input int p);
    bit found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      tick();
      found = (shown_pos == p);
    end
    check("wait_pos_reached", 32'(found), 32'd1);
  endtask

  task automatic set_time(input int h1, input int h0, input int m1, input int m0,
                          input int s1, input int s0);
    H_in1 = 2'(h1); H_in0 = 3'(h0); M_in1 = 4'(m1);
    M_in0 = 4'(m0); S_in1 = 4'(s1); S_in0 = 4'(s0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_an"},  32'(an),        32'h3F);
    check({tag, "_seg"}, 32'(seg),       32'h7F);
    check({tag, "_dp"},  32'(dp),        32'd1);
    check({tag, "_sel"}, 32'(digit_sel), 32'd0);
  endtask

  initial begin
    set_time(0, 6, 5, 9, 0, 0);
    repeat (3) tick();
    check_reset_vals("rst_init");
    reset = 1'b0;
    tick();                                  // position 0
    check("start_sel", 32'(digit_sel), 32'd0);
    check("start_an",  32'(an), 32'h3F);
    repeat (8) tick();                       // position 8: idx2 guard cycle
    check("guard_an", 32'(an), 32'h3F);
    tick();                                  // position 9: M0 = 9
    check("m0_seg", 32'(seg), 32'h10);
    check("m0_an",  32'(an),  32'h3B);
    check("m0_dp",  32'(dp),  32'd0);
    repeat (8) tick();                       // position 17: H0 = 6
    check("h0_seg", 32'(seg), 32'h02);
    check("h0_an",  32'(an),  32'h2F);
    repeat (4) tick();                       // position 21: H1 = 0 blanked
    check("h1_blank_an", 32'(an), 32'h3F);
    check("h1_dp", 32'(dp), 32'd1);
    repeat (26) tick();                      // position 47, two frames done

    // Invalid BCD; frame 2 was already captured, so the dash shows in frame 3
    M_in0 = 4'hC;
    wait_pos(9);
    check("m0_old_frame", 32'(seg), 32'h10);
    wait_pos(9);
    check("m0_dash", 32'(seg), 32'h3F);
    wait_pos(13);
    check("m1_unaffected", 32'(seg), 32'h12);

    // Snapshot coherency across a mid-frame time change
    set_time(0, 6, 5, 9, 5, 9);
    wait_pos(0);
    wait_pos(0);
    wait_pos(12);
    set_time(0, 7, 0, 0, 0, 0);
    wait_pos(13);
    check("coh_m1_old", 32'(seg), 32'h12);
    wait_pos(17);
    check("coh_h0_old", 32'(seg), 32'h02);
    wait_pos(5);
    check("coh_s1_new", 32'(seg), 32'h40);
    wait_pos(17);
    check("coh_h0_new", 32'(seg), 32'h78);

    // Alarm blink: 8 frames on, 8 frames off
    wait_pos(0);
    Alarm = 1'b1;
    repeat (169) tick();
    check("blink_on_last", 32'(an), 32'h3E);
    repeat (24) tick();
    check("blink_off_an",  32'(an),  32'h3F);
    check("blink_off_seg", 32'(seg), 32'h7F);
    check("blink_off_dp",  32'(dp),  32'd1);
    repeat (192) tick();
    check("blink_resume", 32'(an), 32'h3E);
    repeat (192) tick();
    check("blink_off2", 32'(an), 32'h3F);
    Alarm = 1'b0;
    tick();
    check("alarm_drop_resume", 32'(an), 32'h3E);

    // Reset during the OFF phase with Alarm held
    wait_pos(0);
    Alarm = 1'b1;
    repeat (193) tick();
    check("pre_reset_off", 32'(an), 32'h3F);
    reset = 1'b1;
    repeat (3) tick();
    check_reset_vals("rst_mid");
    reset = 1'b0;
    tick();
    check("rst_restart_sel", 32'(digit_sel), 32'd0);
    tick();
    check("rst_phase_on", 32'(an), 32'h3E);
    repeat (168) tick();
    check("rst_frame_cnt_on", 32'(an), 32'h3E);
    repeat (24) tick();
    check("rst_frame_cnt_off", 32'(an), 32'h3F);
    Alarm = 1'b0;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
